rate_pulse_gen: RTL

Parametrised multi-rate tick generator. Produces a one-cycle `pulse` every DIV_k clocks and a square-wave `clk_div` with period 2*DIV_k. The active rate k is chosen from NUM_RATES compile-time divisors, by stepping through them on a button edge or by loading an index directly. It feeds the display/timekeeping logic as the slow-time base, and supports pause and glitch-free rate changes.

---
 rtl/rate_pulse_pkg.sv | 32 +++
 rtl/rise_detect.sv | 25 ++
 rtl/rate_pulse_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/rate_pulse_pkg.sv
// ============================================================================
// rate_pulse_pkg : shared constants and divisor lookup for rate_pulse_gen
// Revision: 1.0
// ============================================================================
`default_nettype none

package rate_pulse_pkg;

  localparam int unsigned DIV_1HZ  = 25000000;
  localparam int unsigned DIV_10HZ = 2500000;
  localparam int unsigned MAX_RATES = 4;

  function automatic logic [31:0] div_for(
    input logic [1:0]  idx,
    input logic [31:0] d0,
    input logic [31:0] d1,
    input logic [31:0] d2,
    input logic [31:0] d3
  );
    logic [31:0] d;
    case (idx)
      2'd0:    d = d0;
      2'd1:    d = d1;
      2'd2:    d = d2;
      default: d = d3;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
// rise_detect : registers a level input and flags its rising edge
// Revision: 1.0
// ============================================================================
`default_nettype none

module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

`default_nettype wire

// File: rtl/rate_pulse_gen.sv
// ============================================================================
// rate_pulse_gen : multi-rate tick / divided-clock generator with pause
// Optional tick counter output enabled by RATE_PULSE_GEN_TICK_COUNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rate_pulse_gen
  import rate_pulse_pkg::*;
#(
  parameter int          CNT_W     = 26,
  parameter int          NUM_RATES = 4,
  parameter int          SEL_W     = 2,
  parameter int unsigned DIV_0     = DIV_1HZ,
  parameter int unsigned DIV_1     = 12500000,
  parameter int unsigned DIV_2     = 5000000,
  parameter int unsigned DIV_3     = DIV_10HZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic             sel_load,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] rate_sel,
  output logic             pulse,
  output logic             clk_div,
  output logic             rate_chg
`ifdef RATE_PULSE_GEN_TICK_COUNT_EN
  ,
  output logic [15:0]      tick_cnt
`endif
);

  localparam int               NR       = (NUM_RATES > int'(MAX_RATES)) ? int'(MAX_RATES) : NUM_RATES;
  localparam logic [SEL_W:0]   NR_W     = (SEL_W+1)'(NR);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NR - 1);

  logic             step_rise;
  logic             change;
  logic [SEL_W-1:0] next_sel;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] counter;

  rise_detect u_rise_detect (
    .clk  (clk),
    .rst  (rst),
    .d    (step),
    .rise (step_rise)
  );

  assign div_cur = CNT_W'(div_for(2'(rate_sel), DIV_0, DIV_1, DIV_2, DIV_3));

  // An out-of-range load swallows a coincident step edge rather than falling through.
  always_comb begin
    change   = 1'b0;
    next_sel = rate_sel;
    if (sel_load) begin
      if ({1'b0, sel_in} < NR_W) begin
        change   = 1'b1;
        next_sel = sel_in;
      end
    end else if (step_rise) begin
      change   = 1'b1;
      next_sel = (rate_sel == LAST_SEL) ? '0 : rate_sel + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_sel <= '0;
      counter  <= CNT_W'(1);
      pulse    <= 1'b0;
      clk_div  <= 1'b0;
      rate_chg <= 1'b0;
    end else begin
      rate_chg <= change;
      if (change) begin
        rate_sel <= next_sel;
        counter  <= CNT_W'(1);
        pulse    <= 1'b0;
      end else if (en) begin
        // >= so a count left over from a longer period terminates at once.
        if (counter >= div_cur) begin
          counter <= CNT_W'(1);
          pulse   <= 1'b1;
          clk_div <= ~clk_div;
        end else begin
          counter <= counter + CNT_W'(1);
          pulse   <= 1'b0;
        end
      end else begin
        pulse <= 1'b0;
      end
    end
  end

`ifdef RATE_PULSE_GEN_TICK_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || change)
      tick_cnt <= 16'd0;
    else if (en && (counter >= div_cur))
      tick_cnt <= tick_cnt + 16'd1;
  end
`else
  // Tick counter absent in this build.
`endif

endmodule

`default_nettype wire
